// File: rtl/alu_pkg.sv
// Shared definitions for pipe_alu: 4-bit opcode encodings and FSM state enum.
// The MUL state exists only when PIPE_ALU_MUL_EN is defined.
// Pure package, no logic.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
`ifdef PIPE_ALU_MUL_EN
      ST_MUL  = 2'd1,
`endif
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, low WIDTH bits of the unsigned product.
// Latency: start edge loads operands, then exactly WIDTH step edges; done rises on the last step.
// No backpressure: done and product hold until the next start.
module alu_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;
   logic             busy;

   // Load on start, then one add/shift step per cycle until WIDTH steps are done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (start) begin
         mcand   <= a;
         mplier  <= b;
         product <= '0;
         cnt     <= '0;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else if (busy) begin
         if (mplier[0])
            product <= product + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (cnt == CW'(WIDTH - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_alu.sv
// Single-request ALU with valid/ready handshake; optional sequential MUL under PIPE_ALU_MUL_EN.
// Latency: 1 cycle for logic/arith/illegal ops, WIDTH+1 cycles for MUL.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module pipe_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   input  logic [3:0]       control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             overflow,
   output logic             illegal
);

   state_t           state;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] res;
   logic             res_ovf;
   logic             res_ill;

   assign sum  = left + right;
   assign diff = left - right;

`ifdef PIPE_ALU_MUL_EN
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   assign mul_start = (state == ST_IDLE) && in_valid && (control == OP_MUL);

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (left),
      .b       (right),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   // Single-cycle result from the live operands; only sampled on the accept edge.
   always_comb begin
      res     = '0;
      res_ovf = 1'b0;
      res_ill = 1'b0;
      case (control)
         OP_AND: res = left & right;
         OP_OR:  res = left | right;
         OP_ADD: begin
            res     = sum;
            res_ovf = (left[WIDTH-1] == right[WIDTH-1]) && (sum[WIDTH-1] != left[WIDTH-1]);
         end
         OP_SUB: begin
            res     = diff;
            res_ovf = (left[WIDTH-1] != right[WIDTH-1]) && (diff[WIDTH-1] != left[WIDTH-1]);
         end
         OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(left) < $signed(right))};
         OP_NOR: res = ~(left | right);
         default: res_ill = 1'b1;
      endcase
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out       <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
`ifdef PIPE_ALU_MUL_EN
                  if (control == OP_MUL) begin
                     state <= ST_MUL;
                  end else
`endif
                  begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                     out       <= res;
                     zero      <= (res == '0);
                     overflow  <= res_ovf;
                     illegal   <= res_ill;
                  end
               end
            end
`ifdef PIPE_ALU_MUL_EN
            ST_MUL: begin
               if (mul_done) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  out       <= mul_product;
                  zero      <= (mul_product == '0);
                  overflow  <= 1'b0;
                  illegal   <= 1'b0;
               end
            end
`endif
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_alu.sv
// Directed-vector bench for pipe_alu (WIDTH=32), both with and without PIPE_ALU_MUL_EN.
// Latency: results are awaited with a bounded edge count and the count itself is checked.
// Backpressure: out_ready is held low and the result is checked for stability.
module tb_pipe_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] left;
   logic [31:0] right;
   logic [3:0]  control;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        zero;
   logic        overflow;
   logic        illegal;

   int n_vec = 0;
   int n_err = 0;

   pipe_alu #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .left      (left),
      .right     (right),
      .control   (control),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero),
      .overflow  (overflow),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one request when in_ready; returns at the negedge one edge after accept.
   task automatic issue(input string tag, input logic [31:0] l, input logic [31:0] r,
                        input logic [3:0] c);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
      left     = l;
      right    = r;
      control  = c;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic await_result(input string tag, input int exp_lat);
      int lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
   endtask

   task automatic retire(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_vld_drop"}, {63'd0, out_valid}, 64'd0);
      check({tag, "_rdy_back"}, {63'd0, in_ready}, 64'd1);
   endtask

   task automatic op(input string tag, input logic [31:0] l, input logic [31:0] r,
                     input logic [3:0] c, input int lat, input logic [31:0] eo,
                     input logic ez, input logic ev, input logic ei);
      issue(tag, l, r, c);
      await_result(tag, lat);
      check({tag, "_out"}, {32'd0, out}, {32'd0, eo});
      check({tag, "_zero"}, {63'd0, zero}, {63'd0, ez});
      check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, ev});
      check({tag, "_ill"}, {63'd0, illegal}, {63'd0, ei});
      retire(tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_vld;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      left      = '0;
      right     = '0;
      control   = '0;
      repeat (3) @(negedge clk);
      check("rst_out", {32'd0, out}, 64'd0);
      check("rst_vld", {63'd0, out_valid}, 64'd0);
      check("rst_zero", {63'd0, zero}, 64'd0);
      check("rst_ovf", {63'd0, overflow}, 64'd0);
      check("rst_ill", {63'd0, illegal}, 64'd0);
      rst = 1'b0;
      check("rst_rdy", {63'd0, in_ready}, 64'd1);

      //  tag          left          right         op       lat out           z     v     i
      op("and0",   32'h00000001, 32'h00000000, 4'b0000, 1, 32'h00000000, 1'b1, 1'b0, 1'b0);
      op("add1",   32'd69,       32'd31,       4'b0010, 1, 32'd100,      1'b0, 1'b0, 1'b0);
      op("add_ov", 32'h7FFFFFFF, 32'h00000001, 4'b0010, 1, 32'h80000000, 1'b0, 1'b1, 1'b0);
      op("add_wr", 32'hFFFFFFFF, 32'h00000001, 4'b0010, 1, 32'h00000000, 1'b1, 1'b0, 1'b0);
      op("sub1",   32'd5,        32'd7,        4'b0110, 1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
      op("sub_ov", 32'h80000000, 32'h00000001, 4'b0110, 1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
      op("slt1",   32'd5,        32'd30,       4'b0111, 1, 32'd1,        1'b0, 1'b0, 1'b0);
      op("slt2",   32'hFFFFFFFF, 32'd0,        4'b0111, 1, 32'd1,        1'b0, 1'b0, 1'b0);
      op("slt3",   32'd30,       32'd5,        4'b0111, 1, 32'd0,        1'b1, 1'b0, 1'b0);
      op("or1",    32'hF0F00000, 32'h00000F0F, 4'b0001, 1, 32'hF0F00F0F, 1'b0, 1'b0, 1'b0);
      op("nor1",   32'h00000000, 32'h00000000, 4'b1100, 1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      op("nor2",   32'hFFFFFFFF, 32'h00000000, 4'b1100, 1, 32'h00000000, 1'b1, 1'b0, 1'b0);
      op("ill3",   32'h12345678, 32'h9ABCDEF0, 4'b0011, 1, 32'h00000000, 1'b1, 1'b0, 1'b1);
`ifdef PIPE_ALU_MUL_EN
      op("mul1",   32'd1234,     32'd5678,     4'b1000, 33, 32'd7006652, 1'b0, 1'b0, 1'b0);
      op("mul0",   32'd0,        32'hDEADBEEF, 4'b1000, 33, 32'd0,       1'b1, 1'b0, 1'b0);
`else
      op("mul_ill", 32'd1234,    32'd5678,     4'b1000, 1, 32'h00000000, 1'b1, 1'b0, 1'b1);
`endif

      // Backpressure: result must hold while a competing request waits.
      issue("bp", 32'd10, 32'd20, 4'b0010);
      await_result("bp", 1);
      left     = 32'd1;
      right    = 32'd1;
      control  = 4'b0000;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out", {32'd0, out}, 64'd30);
         check("bp_vld", {63'd0, out_valid}, 64'd1);
         check("bp_rdy", {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      retire("bp");
      op("after_bp", 32'd1, 32'd1, 4'b0010, 1, 32'd2, 1'b0, 1'b0, 1'b0);

      // Reset ten edges into an operation abandons it.
      issue("rst_mid", 32'd1234, 32'd5678, 4'b1000);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_vld", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_rdy", {63'd0, in_ready}, 64'd1);
      seen_vld = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen_vld = 1'b1;
      end
      check("rst_mid_no_vld", {63'd0, seen_vld}, 64'd0);
      op("post_rst_add", 32'd2, 32'd3, 4'b0010, 1, 32'd5, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 left  input  WIDTH  operand A, sampled on accept.
REQ-007 right  input  WIDTH  operand B, sampled on accept.
REQ-008 control  input  4  opcode, sampled on accept.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 out  output  WIDTH  result.
REQ-012 zero  output  1  high when out == 0.
REQ-013 overflow  output  1  signed overflow of ADD/SUB, else 0.
REQ-014 illegal  output  1  opcode not supported in this build.

Function
REQ-015 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1100 NOR, 1000 MUL (low WIDTH bits of unsigned product).
REQ-016 Accept occurs on an edge where in_valid and in_ready are both high; operands and opcode are latched at that edge and never re-sampled.
REQ-017 FSM states IDLE, MUL, DONE; in_ready = (state == IDLE).
REQ-018 IDLE + accept of a non-MUL opcode: result registered at the accept edge; DONE entered; out_valid high from the next cycle (latency 1).
REQ-019 IDLE + accept of MUL (when enabled): MUL entered; one shift-add step per cycle for exactly WIDTH cycles; then DONE (out_valid after WIDTH+1 edges from accept).
REQ-020 DONE: out, zero, overflow, illegal held stable while out_valid high and out_ready low.
REQ-021 DONE with out_ready high: return to IDLE at that edge; out_valid drops the next cycle; no new accept in that same cycle.
REQ-022 ADD/SUB wrap modulo 2^WIDTH; overflow = operand signs equal (SUB: B inverted) and result sign differs.
REQ-023 Undefined or disabled opcode: out = 0, zero = 1, overflow = 0, illegal = 1, latency 1.
REQ-024 in_valid during MUL or DONE is ignored; requester must hold it until in_ready.

Reset
REQ-025 On rst: state IDLE, out = 0, out_valid = 0, zero = 0, overflow = 0, illegal = 0, multiplier registers cleared.
REQ-026 Reset mid-MUL or in DONE abandons the operation; no out_valid follows the reset release.
REQ-027 in_ready high in the first cycle after rst deasserts.

Configuration
REQ-028 Macro PIPE_ALU_MUL_EN defined: MUL opcode and state are implemented per REQ-019.
REQ-029 PIPE_ALU_MUL_EN undefined: no multiplier logic or MUL state; opcode 1000 is handled as illegal per REQ-023.

Structure
REQ-030 Shared package alu_pkg holds the 4-bit opcode constants and the FSM state enum.
REQ-031 One sub-module, alu_mul_seq (iterative shift-add multiplier, start/done handshake), instantiated only under PIPE_ALU_MUL_EN.
REQ-032 Combinational ops reside in pipe_alu itself; no other sub-modules.

Verification
REQ-033 AND: left=0x00000001, right=0x00000000, control=0000 -> out=0, zero=1, out_valid one cycle after accept.
REQ-034 ADD: left=69, right=31, control=0010 -> out=100, overflow=0; then left=0x7FFFFFFF, right=1 -> out=0x80000000, overflow=1.
REQ-035 SLT: left=5, right=30 -> out=1; left=0xFFFFFFFF (-1), right=0 -> out=1; left=30, right=5 -> out=0.
REQ-036 Backpressure: out_ready low 5 cycles after out_valid -> out stable, in_ready low throughout; out_ready high -> in_ready high next cycle.
REQ-037 MUL with PIPE_ALU_MUL_EN: left=1234, right=5678 -> out=7006652 exactly 33 edges after accept (WIDTH=32); without macro -> illegal=1, out=0 at latency 1.
REQ-038 rst asserted at MUL cycle 10 -> out_valid stays 0, in_ready high after release, next ADD 2+3 returns 5.
